// File: rtl/b8b10_pkg.sv
// b8b10_pkg: shared constants, tables and types for the b8b10_enc stage.
//   RD_NEG/RD_POS   running-disparity encodings (1 = positive)
//   K28_5           comma byte value
//   LEGAL_K         the twelve bytes that are valid control characters
//   T4_RDN/T4_RDP   3b/4b sub-block tables (fghj), selected by RD after the 6b block
//   K28_5_RDN/RDP   full K28.5 symbols for each starting RD
package b8b10_pkg;
  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [4:0] X_K28 = 5'd28;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  localparam int NUM_LEGAL_K = 12;
  // K28.0..K28.7, K23.7, K27.7, K29.7, K30.7
  localparam logic [7:0] LEGAL_K [NUM_LEGAL_K] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  localparam logic [3:0] T4_RDN [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  localparam logic [3:0] T4_RDP [8] = '{
    4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001
  };

  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } enc_req_t;

  function automatic logic is_legal_k(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_K; i++)
      if (b == LEGAL_K[i]) hit = 1'b1;
    return hit;
  endfunction
endpackage

// File: rtl/b8b10_enc_if.sv
// b8b10_enc_if: byte-in / symbol-out handshake bundle of the encoder stage.
//   master: upstream byte source + downstream symbol sink (drives in_*, out_ready)
//   slave : the encoder (drives in_ready, out_*, rd_state)
interface b8b10_enc_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_k;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sym;
  logic       out_k_err;
  logic       rd_state;

  modport master (
    output in_valid, in_data, in_k, out_ready,
    input  in_ready, out_valid, out_sym, out_k_err, rd_state
  );
  modport slave (
    input  in_valid, in_data, in_k, out_ready,
    output in_ready, out_valid, out_sym, out_k_err, rd_state
  );
endinterface

// File: rtl/b3b4.sv
// b3b4: combinational 3b/4b sub-block encoder.
//   y_i    HGF
//   rd6_i  RD after the 6b sub-block (1 = positive)
//   k_i    byte is a legal control character
//   x_i    EDCBA (selects the alternate D.x.A7 encoding)
//   fghj_o 4b sub-block, f in bit 3
module b3b4
  import b8b10_pkg::*;
(
  input  logic [2:0] y_i,
  input  logic       rd6_i,
  input  logic       k_i,
  input  logic [4:0] x_i,
  output logic [3:0] fghj_o
);
  logic a7;

  always_comb begin
    // A7 avoids a run of five identical bits across the e/i - f/g boundary.
    a7 = (y_i == 3'd7) &&
         (k_i ||
          ((rd6_i == RD_NEG) && (x_i inside {5'd17, 5'd18, 5'd20})) ||
          ((rd6_i == RD_POS) && (x_i inside {5'd11, 5'd13, 5'd14})));
    if (a7)
      fghj_o = (rd6_i == RD_POS) ? 4'b1000 : 4'b0111;
    else
      fghj_o = (rd6_i == RD_POS) ? T4_RDP[y_i] : T4_RDN[y_i];
    // K28.1/.2/.5/.6 flip their balanced 4b code so the comma stays unique.
    if (k_i && (x_i == X_K28) && (rd6_i == RD_NEG) && (y_i inside {3'd1, 3'd2, 3'd5, 3'd6}))
      fghj_o = ~fghj_o;
  end
endmodule

// File: rtl/b5b6.sv
// b5b6: combinational 5b/6b data encoder.
//   x_i      EDCBA
//   dsel_i   1 = current RD negative (use RD- column), 0 = RD positive
//   abcdei_o 6b sub-block, a in bit 5
module b5b6 (
  input  logic [4:0] x_i,
  input  logic       dsel_i,
  output logic [5:0] abcdei_o
);
  // RD- column; the RD+ code is its complement unless the code is balanced.
  localparam logic [5:0] TBL_RDN [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  logic [5:0] rdn;
  logic       same;

  assign rdn = TBL_RDN[x_i];
  // D.7 is balanced but still alternates (111000/000111) to bound run length.
  assign same = ($countones(rdn) == 3) && (x_i != 5'd7);
  assign abcdei_o = (dsel_i || same) ? rdn : ~rdn;
endmodule

// File: rtl/b8b10_enc.sv
// b8b10_enc: registered 8b/10b encoder stage between xbar egress and the serializer.
//   clk, reset_n  clock, async active-low reset
//   bus (slave)   in_valid/in_ready/in_data/in_k byte side,
//                 out_valid/out_ready/out_sym/out_k_err symbol side,
//                 rd_state = running disparity after the last accepted byte
// One output register, no skid: in_ready = !out_valid | out_ready.
module b8b10_enc
  import b8b10_pkg::*;
#(
  parameter logic RD_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  b8b10_enc_if.slave  bus
);
  enc_req_t   req;
  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok, k_use, in_rdy, accept;
  logic [5:0] sub6_raw, sub6;
  logic [3:0] sub4;
  logic       rd6, rd4;

  logic       vld_q, vld_d;
  logic [9:0] sym_q, sym_d;
  logic       kerr_q, kerr_d;
  logic       rd_q, rd_d;

  assign req    = '{k: bus.in_k, data: bus.in_data};
  assign x      = req.data[4:0];
  assign y      = req.data[7:5];
  assign k_ok   = is_legal_k(req.data);
  // Illegal K codes fall through to the data path.
  assign k_use  = req.k & k_ok;
  assign in_rdy = ~vld_q | bus.out_ready;
  assign accept = bus.in_valid & in_rdy;

  b5b6 u_b5b6 (
    .x_i      (x),
    .dsel_i   (rd_q == RD_NEG),
    .abcdei_o (sub6_raw)
  );

  always_comb begin
    sub6 = sub6_raw;
    if (k_use && (x == X_K28))
      sub6 = (rd_q == RD_POS) ? 6'b110000 : 6'b001111;
    rd6 = rd_q;
    if ($countones(sub6) > 3)      rd6 = RD_POS;
    else if ($countones(sub6) < 3) rd6 = RD_NEG;
  end

  b3b4 u_b3b4 (
    .y_i    (y),
    .rd6_i  (rd6),
    .k_i    (k_use),
    .x_i    (x),
    .fghj_o (sub4)
  );

  always_comb begin
    rd4 = rd6;
    if ($countones(sub4) > 2)      rd4 = RD_POS;
    else if ($countones(sub4) < 2) rd4 = RD_NEG;
  end

  always_comb begin
    vld_d  = vld_q;
    sym_d  = sym_q;
    kerr_d = kerr_q;
    rd_d   = rd_q;
    if (accept) begin
      vld_d  = 1'b1;
      sym_d  = {sub6, sub4};
      kerr_d = req.k & ~k_ok;
      rd_d   = rd4;
    end else if (bus.out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      sym_q  <= '0;
      kerr_q <= 1'b0;
      rd_q   <= RD_INIT;
    end else begin
      vld_q  <= vld_d;
      sym_q  <= sym_d;
      kerr_q <= kerr_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_sym   = sym_q;
  assign bus.out_k_err = kerr_q;
  assign bus.rd_state  = rd_q;
endmodule

// File: tb/tb_b8b10_enc.sv
// tb_b8b10_enc: directed vector table, handshake/reset sequences and a randomized
// run scored against a table-based 8b/10b reference plus stream properties.
module tb_b8b10_enc;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  b8b10_enc_if bus ();
  b8b10_enc #(.RD_INIT(1'b0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Reference code tables: both 6b columns spelled out explicitly.
  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100
  };
  localparam logic [3:0] T4N [8] = '{4'hB, 4'h9, 4'h5, 4'hC, 4'hD, 4'hA, 4'h6, 4'hE};
  localparam logic [3:0] T4P [8] = '{4'h4, 4'h9, 4'h5, 4'h3, 4'h2, 4'hA, 4'h6, 4'h1};
  localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                        8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  typedef struct {
    logic [7:0] data;
    logic       k;
    logic [9:0] sym;
    logic       err;
    logic       rd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_k      = k;
    bus.out_ready = ordy;
  endtask

  task automatic ref_enc(input logic [7:0] d, input logic k, input logic rd,
                         output logic [9:0] sym, output logic err, output logic rd_o);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal, rd6, a7;
    logic [5:0] s6;
    logic [3:0] s4;
    int         n;
    x = d[4:0];
    y = d[7:5];
    legal = k && ((x == 5'd28) || ((y == 3'd7) && (x inside {5'd23, 5'd27, 5'd29, 5'd30})));
    err = k && !legal;
    if (legal && x == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
    else                      s6 = rd ? T6P[x] : T6N[x];
    n = $countones(s6);
    rd6 = (n > 3) ? 1'b1 : (n < 3) ? 1'b0 : rd;
    a7 = (y == 3'd7) && (legal || (!rd6 && (x inside {5'd17, 5'd18, 5'd20})) ||
                                 (rd6 && (x inside {5'd11, 5'd13, 5'd14})));
    if (a7) s4 = rd6 ? 4'b1000 : 4'b0111;
    else    s4 = rd6 ? T4P[y] : T4N[y];
    if (legal && x == 5'd28 && !rd6 && (y inside {3'd1, 3'd2, 3'd5, 3'd6})) s4 = ~s4;
    n = $countones(s4);
    rd_o = (n > 2) ? 1'b1 : (n < 2) ? 1'b0 : rd6;
    sym = {s6, s4};
  endtask

  initial begin
    logic       exp_v, exp_err, exp_rd, prev_rd, new_sym, iv, ordy, kk, last_bit, b;
    logic [9:0] exp_sym;
    logic [7:0] dd;
    int         run, maxrun, n;

    // ---------------- reset state ----------------
    reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_sym", bus.out_sym, 0);
    chk("rst out_k_err", bus.out_k_err, 0);
    chk("rst rd_state", bus.rd_state, 0);
    chk("rst in_ready", bus.in_ready, 1);
    reset_n = 1'b1;

    // ---------------- vector table (RD chains from reset) ----------------
    vecs.push_back('{8'h00, 1'b0, 10'h274, 1'b0, 1'b0}); // D.0.0 RD-
    vecs.push_back('{8'hBC, 1'b1, 10'h0FA, 1'b0, 1'b1}); // K28.5 RD-
    vecs.push_back('{8'hBC, 1'b1, 10'h305, 1'b0, 1'b0}); // K28.5 RD+
    vecs.push_back('{8'hB5, 1'b0, 10'h2AA, 1'b0, 1'b0}); // D.21.5 RD-
    vecs.push_back('{8'hBC, 1'b1, 10'h0FA, 1'b0, 1'b1});
    vecs.push_back('{8'hB5, 1'b0, 10'h2AA, 1'b0, 1'b1}); // D.21.5 RD+
    vecs.push_back('{8'h00, 1'b1, 10'h18B, 1'b1, 1'b1}); // illegal K0.0 RD+
    vecs.push_back('{8'hF7, 1'b1, 10'h057, 1'b0, 1'b1}); // K23.7 RD+
    vecs.push_back('{8'hFC, 1'b1, 10'h307, 1'b0, 1'b1}); // K28.7 RD+
    vecs.push_back('{8'hF1, 1'b0, 10'h231, 1'b0, 1'b0}); // D.17.7 RD+
    vecs.push_back('{8'hF1, 1'b0, 10'h237, 1'b0, 1'b1}); // D.17.7 RD- (A7)
    vecs.push_back('{8'hEB, 1'b0, 10'h348, 1'b0, 1'b0}); // D.11.7 RD+ (A7)
    vecs.push_back('{8'hE1, 1'b1, 10'h1D1, 1'b1, 1'b0}); // illegal K1.7 RD-
    vecs.push_back('{8'h3C, 1'b1, 10'h0F9, 1'b0, 1'b1}); // K28.1 RD-
    vecs.push_back('{8'h3C, 1'b1, 10'h306, 1'b0, 1'b0}); // K28.1 RD+
    vecs.push_back('{8'h07, 1'b0, 10'h38B, 1'b0, 1'b1}); // D.7.0 RD-
    vecs.push_back('{8'h07, 1'b0, 10'h074, 1'b0, 1'b0}); // D.7.0 RD+
    vecs.push_back('{8'h1C, 1'b1, 10'h0F4, 1'b0, 1'b0}); // K28.0 RD-
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].data, vecs[i].k, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d out_sym", i), bus.out_sym, vecs[i].sym);
      chk($sformatf("vec%0d out_k_err", i), bus.out_k_err, vecs[i].err);
      chk($sformatf("vec%0d rd_state", i), bus.rd_state, vecs[i].rd);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("drain out_valid", bus.out_valid, 0);

    // ---------------- backpressure ----------------
    drive(1'b1, 8'hBC, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp first sym", bus.out_sym, 10'h0FA);
    chk("bp first rd", bus.rd_state, 1);
    drive(1'b1, 8'hB5, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d in_ready", c), bus.in_ready, 0);
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", c), bus.out_valid, 1);
      chk($sformatf("bp%0d sym stable", c), bus.out_sym, 10'h0FA);
      chk($sformatf("bp%0d rd hold", c), bus.rd_state, 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp release in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("bp release valid", bus.out_valid, 1);
    chk("bp release sym", bus.out_sym, 10'h2AA);
    chk("bp release rd", bus.rd_state, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp drain valid", bus.out_valid, 0);

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 8'hBC, 1'b1, 1'b1);
    @(negedge clk);
    chk("mr sym0", bus.out_sym, 10'h305);
    @(negedge clk);
    chk("mr sym1", bus.out_sym, 10'h0FA);
    chk("mr rd1", bus.rd_state, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("mr hold valid", bus.out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mr rst valid", bus.out_valid, 0);
    chk("mr rst rd", bus.rd_state, 0);
    chk("mr rst sym", bus.out_sym, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);

    // ---------------- randomized run ----------------
    exp_v = 1'b0; exp_sym = '0; exp_err = 1'b0; exp_rd = 1'b0; prev_rd = 1'b0;
    new_sym = 1'b0; run = 0; last_bit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk("rand out_valid", bus.out_valid, exp_v);
      if (exp_v) begin
        chk("rand out_sym", bus.out_sym, exp_sym);
        chk("rand out_k_err", bus.out_k_err, exp_err);
      end
      chk("rand rd_state", bus.rd_state, exp_rd);
      if (new_sym) begin
        n = $countones(bus.out_sym);
        chk("rand ones", n inside {4, 5, 6}, 1);
        chk("rand disparity", (n == 5) || (n == 6 && !prev_rd) || (n == 4 && prev_rd), 1);
        chk("rand rd vs sym", bus.rd_state, (n == 6) ? 1 : (n == 4) ? 0 : prev_rd);
        maxrun = 0;
        for (int j = 9; j >= 0; j--) begin
          b = bus.out_sym[j];
          run = (run > 0 && b == last_bit) ? run + 1 : 1;
          last_bit = b;
          if (run > maxrun) maxrun = run;
        end
        chk("rand run length", maxrun <= 5, 1);
      end

      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      kk   = ($urandom_range(0, 3) == 0);
      dd   = 8'($urandom);
      if (kk && $urandom_range(0, 1) == 1) dd = KLIST[$urandom_range(0, 11)];
      drive(iv, dd, kk, ordy);
      #1 chk("rand in_ready", bus.in_ready, !exp_v || ordy);
      new_sym = 1'b0;
      if (iv && (!exp_v || ordy)) begin
        prev_rd = exp_rd;
        ref_enc(dd, kk, prev_rd, exp_sym, exp_err, exp_rd);
        exp_v = 1'b1;
        new_sym = 1'b1;
      end else if (ordy) begin
        exp_v = 1'b0;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
